// File: rtl/hms_ctrl_pkg.sv
// rtl/hms_ctrl_pkg.sv - HMS controller mode/position encodings and blink field helpers
package hms_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_e;

  localparam int BLINK_SEC_LSB  = 0;
  localparam int BLINK_MIN_LSB  = 2;
  localparam int BLINK_HOUR_LSB = 4;

  function automatic logic [5:0] blink_bits(input pos_e pos);
    logic [5:0] m;
    m = '0;
    case (pos)
      POS_SEC:  m[BLINK_SEC_LSB +: 2]  = 2'b11;
      POS_MIN:  m[BLINK_MIN_LSB +: 2]  = 2'b11;
      POS_HOUR: m[BLINK_HOUR_LSB +: 2] = 2'b11;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hms_mode_ctrl_sw_debounce.sv
// rtl/hms_mode_ctrl_sw_debounce.sv - active-low button synchronizer, debouncer and press pulse
module sw_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sw_n,
  output logic o_pressed,
  output logic o_press
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_level_n;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_done;

  assign w_done    = (r_cnt == CW'(DEB_CYC - 1));
  assign o_pressed = ~r_level_n;
  assign o_press   = r_press;

  // Level flips only after DEB_CYC consecutive samples that differ from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_level_n <= 1'b1;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1    <= i_sw_n;
      r_s2    <= r_s1;
      r_press <= 1'b0;
      if (r_s2 == r_level_n) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt     <= '0;
        r_level_n <= r_s2;
        r_press   <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/hms_mode_ctrl.sv
// rtl/hms_mode_ctrl.sv - HMS clock mode FSM, timebase, setting pulses and blink mask
// Optional idle auto-exit to CLOCK mode when HMS_CTRL_AUTO_EXIT_EN is defined.
module hms_mode_ctrl
  import hms_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int DEB_MS      = 20,
  parameter int RPT_DLY_MS  = 500,
  parameter int RPT_MS      = 100,
  parameter int BLINK_HZ    = 2,
  parameter int AUTO_EXIT_S = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_inc,
  input  logic       i_sec_max,
  input  logic       i_min_max,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_en,
  output logic       o_min_en,
  output logic       o_hour_en,
  output logic       o_alm_min_en,
  output logic       o_alm_hour_en,
  output logic [5:0] o_blink_mask
);

  localparam int DEB_CYC  = int'((longint'(CLK_HZ) * DEB_MS) / 1000);
  localparam int DLY_CYC  = int'((longint'(CLK_HZ) * RPT_DLY_MS) / 1000);
  localparam int RPT_CYC  = int'((longint'(CLK_HZ) * RPT_MS) / 1000);
  localparam int HALF_CYC = CLK_HZ / (2 * BLINK_HZ);
  localparam int TB_W     = $clog2(CLK_HZ);
  localparam int RC_W     = $clog2(((DLY_CYC > RPT_CYC) ? DLY_CYC : RPT_CYC) + 1);
  localparam int BL_W     = $clog2(HALF_CYC + 1);

  logic w_mode_press, w_pos_press, w_inc_press, w_inc_held;
  logic w_unused_mode_lvl, w_unused_pos_lvl;
  logic w_any_press, w_auto_exit, w_tick, w_tb_out, w_set, w_setup, w_alarm, w_rpt_fire;

  mode_e r_mode, w_mode_nxt;
  pos_e  r_pos, w_pos_nxt;

  logic [TB_W-1:0] r_tb_cnt;
  logic [RC_W-1:0] r_rpt_cnt;
  logic            r_rpt_act;
  logic [BL_W-1:0] r_bl_cnt;
  logic            r_blink;

  sw_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
    .clk(clk), .rst_n(rst_n), .i_sw_n(i_sw_mode), .o_pressed(w_unused_mode_lvl), .o_press(w_mode_press)
  );
  sw_debounce #(.DEB_CYC(DEB_CYC)) u_deb_pos (
    .clk(clk), .rst_n(rst_n), .i_sw_n(i_sw_pos), .o_pressed(w_unused_pos_lvl), .o_press(w_pos_press)
  );
  sw_debounce #(.DEB_CYC(DEB_CYC)) u_deb_inc (
    .clk(clk), .rst_n(rst_n), .i_sw_n(i_sw_inc), .o_pressed(w_inc_held), .o_press(w_inc_press)
  );

  assign w_any_press = w_mode_press | w_pos_press | w_inc_press;

`ifdef HMS_CTRL_AUTO_EXIT_EN
  localparam longint IDLE_CYC = longint'(AUTO_EXIT_S) * CLK_HZ;
  localparam int     IW       = $clog2(IDLE_CYC + 1);
  logic [IW-1:0] r_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_idle <= '0;
    else if (w_any_press || r_mode == MODE_CLOCK) r_idle <= '0;
    else                                      r_idle <= r_idle + IW'(1);
  end

  assign w_auto_exit = (r_idle == IW'(IDLE_CYC));
`else
  localparam int unused_auto_exit_s = AUTO_EXIT_S;
  assign w_auto_exit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_CLOCK;
      r_pos  <= POS_SEC;
    end else begin
      r_mode <= w_mode_nxt;
      r_pos  <= w_pos_nxt;
    end
  end

  // Mode press outranks a same-cycle position press.
  always_comb begin
    w_mode_nxt = r_mode;
    w_pos_nxt  = r_pos;
    if (w_auto_exit || !(r_mode inside {MODE_CLOCK, MODE_SETUP, MODE_ALARM})) begin
      w_mode_nxt = MODE_CLOCK;
      w_pos_nxt  = POS_SEC;
    end else if (w_mode_press) begin
      case (r_mode)
        MODE_CLOCK: begin w_mode_nxt = MODE_SETUP; w_pos_nxt = POS_SEC; end
        MODE_SETUP: begin w_mode_nxt = MODE_ALARM; w_pos_nxt = POS_MIN; end
        default:    begin w_mode_nxt = MODE_CLOCK; w_pos_nxt = POS_SEC; end
      endcase
    end else if (w_pos_press) begin
      if (r_mode == MODE_SETUP) begin
        case (r_pos)
          POS_SEC: w_pos_nxt = POS_MIN;
          POS_MIN: w_pos_nxt = POS_HOUR;
          default: w_pos_nxt = POS_SEC;
        endcase
      end else if (r_mode == MODE_ALARM) begin
        if (r_pos == POS_MIN) w_pos_nxt = POS_HOUR;
        else                  w_pos_nxt = POS_MIN;
      end
    end
  end

  assign w_setup = (r_mode == MODE_SETUP);
  assign w_alarm = (r_mode == MODE_ALARM);
  assign w_tick  = (r_tb_cnt == TB_W'(CLK_HZ - 1));
  assign w_tb_out = w_tick && (r_mode == MODE_CLOCK || r_mode == MODE_ALARM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_tb_cnt <= '0;
    else if (w_setup || w_tick || w_auto_exit) r_tb_cnt <= '0;
    else                                   r_tb_cnt <= r_tb_cnt + TB_W'(1);
  end

  // Repeat is armed by an inc press; mode/pos presses or inc release disarm it.
  assign w_rpt_fire = r_rpt_act && (r_rpt_cnt == '0);
  assign w_set      = w_inc_press | w_rpt_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt_act <= 1'b0;
      r_rpt_cnt <= '0;
    end else if (w_mode_press || w_pos_press || !w_inc_held) begin
      r_rpt_act <= 1'b0;
    end else if (w_inc_press) begin
      r_rpt_act <= (r_mode != MODE_CLOCK);
      r_rpt_cnt <= RC_W'(DLY_CYC - 1);
    end else if (w_rpt_fire) begin
      r_rpt_cnt <= RC_W'(RPT_CYC - 1);
    end else if (r_rpt_act) begin
      r_rpt_cnt <= r_rpt_cnt - RC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bl_cnt <= '0;
      r_blink  <= 1'b0;
    end else if (w_any_press) begin
      r_bl_cnt <= '0;
      r_blink  <= 1'b0;
    end else if (r_bl_cnt == BL_W'(HALF_CYC - 1)) begin
      r_bl_cnt <= '0;
      r_blink  <= ~r_blink;
    end else begin
      r_bl_cnt <= r_bl_cnt + BL_W'(1);
    end
  end

  assign o_mode        = r_mode;
  assign o_position    = r_pos;
  assign o_sec_en      = w_tb_out | (w_setup & w_set & (r_pos == POS_SEC));
  assign o_min_en      = (w_tb_out & i_sec_max) | (w_setup & w_set & (r_pos == POS_MIN));
  assign o_hour_en     = (w_tb_out & i_sec_max & i_min_max) | (w_setup & w_set & (r_pos == POS_HOUR));
  assign o_alm_min_en  = w_alarm & w_set & (r_pos == POS_MIN);
  assign o_alm_hour_en = w_alarm & w_set & (r_pos == POS_HOUR);
  assign o_blink_mask  = (r_blink && r_mode != MODE_CLOCK) ? blink_bits(r_pos) : 6'b0;

endmodule

// File: tb/tb_hms_mode_ctrl.sv
// tb/tb_hms_mode_ctrl.sv - scoreboard bench for hms_mode_ctrl
module tb_hms_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_sw_mode, i_sw_pos, i_sw_inc, i_sec_max, i_min_max;
  logic [1:0] o_mode, o_position;
  logic       o_sec_en, o_min_en, o_hour_en, o_alm_min_en, o_alm_hour_en;
  logic [5:0] o_blink_mask;

  hms_mode_ctrl #(
    .CLK_HZ(1000), .DEB_MS(4), .RPT_DLY_MS(20), .RPT_MS(5), .BLINK_HZ(50), .AUTO_EXIT_S(30)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_sw_mode(i_sw_mode), .i_sw_pos(i_sw_pos), .i_sw_inc(i_sw_inc),
    .i_sec_max(i_sec_max), .i_min_max(i_min_max),
    .o_mode(o_mode), .o_position(o_position),
    .o_sec_en(o_sec_en), .o_min_en(o_min_en), .o_hour_en(o_hour_en),
    .o_alm_min_en(o_alm_min_en), .o_alm_hour_en(o_alm_hour_en),
    .o_blink_mask(o_blink_mask)
  );

  always #5 clk = ~clk;

  // enable vector bits: {alm_hour, alm_min, hour, min, sec}
  typedef struct {
    int cyc;
    int en;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void sb_push(input int c, input int en);
    exp_t e;
    int   i;
    e.cyc = c;
    e.en  = en;
    i = 0;
    while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
    exp_q.insert(i, e);
  endfunction

  function automatic int en_vec();
    return int'({o_alm_hour_en, o_alm_min_en, o_hour_en, o_min_en, o_sec_en});
  endfunction

  always @(negedge clk) begin : monitor
    int   en;
    exp_t e;
    en = en_vec();
    if (rst_n && en != 0) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", en, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("pulse_cycle", cyc, e.cyc);
        check_eq("pulse_en", en, e.en);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic press_btn(input int which, input int hold);
    case (which)
      0: i_sw_mode = 1'b0;
      1: i_sw_pos  = 1'b0;
      default: i_sw_inc = 1'b0;
    endcase
    repeat (hold) @(negedge clk);
    case (which)
      0: i_sw_mode = 1'b1;
      1: i_sw_pos  = 1'b1;
      default: i_sw_inc = 1'b1;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    i_sw_mode = 1'b1; i_sw_pos = 1'b1; i_sw_inc = 1'b1;
    i_sec_max = 1'b0; i_min_max = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_mode", int'(o_mode), 0);
    check_eq("rst_pos", int'(o_position), 0);
    check_eq("rst_mask", int'(o_blink_mask), 0);
    check_eq("rst_en", en_vec(), 0);

    sb_push(999, 1); sb_push(1999, 1); sb_push(2999, 1);
    rst_n = 1'b1;
    wait_until(3000);
    check_eq("idle_mode", int'(o_mode), 0);
    check_eq("idle_mask", int'(o_blink_mask), 0);

    // carry chain on a tick
    wait_until(3990);
    i_sec_max = 1'b1; i_min_max = 1'b1;
    sb_push(3999, 7);
    wait_until(4005);
    i_sec_max = 1'b0; i_min_max = 1'b0;

    // CLOCK -> SETUP, blink of SEC field
    wait_until(4100);
    press_btn(0, 8);
    check_eq("setup_mode", int'(o_mode), 1);
    check_eq("setup_pos", int'(o_position), 0);
    wait_until(4110); check_eq("blink_vis0", int'(o_blink_mask), 0);
    wait_until(4120); check_eq("blink_sec", int'(o_blink_mask), 3);
    wait_until(4130); check_eq("blink_vis1", int'(o_blink_mask), 0);

    wait_until(4150);
    sb_push(4156, 1);
    press_btn(2, 8);

    // pos SEC -> MIN -> HOUR, then held inc with auto-repeat
    wait_until(4200); press_btn(1, 8);
    wait_until(4230); press_btn(1, 8);
    wait_until(4240); check_eq("setup_pos_hour", int'(o_position), 2);
    wait_until(4245); check_eq("blink_hour_vis", int'(o_blink_mask), 0);
    wait_until(4250); check_eq("blink_hour", int'(o_blink_mask), 48);
    wait_until(4260);
    sb_push(4266, 4); sb_push(4286, 4); sb_push(4291, 4);
    sb_push(4296, 4); sb_push(4301, 4); sb_push(4306, 4);
    press_btn(2, 40);

    // SETUP -> ALARM; timebase restarts from 0 at the switch
    wait_until(4350);
    sb_push(5356, 1); sb_push(6356, 1);
    press_btn(0, 8);
    wait_until(4360);
    check_eq("alarm_mode", int'(o_mode), 2);
    check_eq("alarm_pos", int'(o_position), 1);
    wait_until(4400);
    sb_push(4406, 8);
    press_btn(2, 8);
    wait_until(4430); press_btn(1, 8);
    wait_until(4440); check_eq("alarm_pos_hour", int'(o_position), 2);
    wait_until(4460);
    sb_push(4466, 16);
    press_btn(2, 8);

    // bouncing inc collapses to one press, then repeats until reset
    wait_until(6400);
    sb_push(6414, 16); sb_push(6434, 16); sb_push(6439, 16);
    for (int i = 0; i < 5; i++) begin
      i_sw_inc = (i % 2 == 1);
      repeat (2) @(negedge clk);
    end
    wait_until(6443);
    @(posedge clk);
    #1;
    check_eq("rpt_before_rst", int'(o_alm_hour_en), 1);
    rst_n = 1'b0;
    i_sw_inc = 1'b1;
    i_sw_mode = 1'b0;
    #1;
    check_eq("async_rst_en", en_vec(), 0);
    check_eq("async_rst_mode", int'(o_mode), 0);
    check_eq("async_rst_pos", int'(o_position), 0);
    check_eq("async_rst_mask", int'(o_blink_mask), 0);
    repeat (3) @(negedge clk);
    check_eq("sb_drained", exp_q.size(), 0);

    // mode button held through reset is debounced into a press
    rst_n = 1'b1;
    wait_until(6); check_eq("held_mode_c6", int'(o_mode), 0);
    wait_until(7); check_eq("held_mode_c7", int'(o_mode), 1);
    i_sw_mode = 1'b1;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
